// File: rtl/seg_capture_n.sv
// seg_capture_n: rebuilds 4-bit digit frames from a multiplexed active-low seven-segment bus.
// Optional hex (A-F) decode is enabled by defining SEG_CAPTURE_HEX_EN.
module seg_capture_n #(
   parameter int unsigned NDIG          = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        segs_n,
   input  logic [NDIG-1:0]   an_n,
   input  logic              frame_ready,
   output logic              frame_valid,
   output logic [4*NDIG-1:0] frame_digits,
   output logic [NDIG-1:0]   frame_blank,
   output logic [NDIG-1:0]   frame_err,
   output logic              glitch
);

   localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

   typedef enum logic {COLLECT, PRESENT} state_t;

   state_t              state_q, state_d;
   logic [NDIG+6:0]     samp_q;
   logic [7:0]          run_q, run_d;
   logic [NDIG-1:0]     mask_q, mask_d;
   logic [4*NDIG-1:0]   slot_q, slot_d;
   logic [NDIG-1:0]     sblank_q, sblank_d;
   logic [NDIG-1:0]     serr_q, serr_d;
   logic [4*NDIG-1:0]   fdig_q, fdig_d;
   logic [NDIG-1:0]     fblank_q, fblank_d;
   logic [NDIG-1:0]     ferr_q, ferr_d;
   logic                glitch_q;

   logic [NDIG+6:0]     samp_now;
   logic [NDIG-1:0]     sel;
   logic                sel_any, sel_one, multi;
   logic                new_run, capture;
   logic [5:0]          dec;

   // Result packing: {err, blank, value}
   function automatic logic [5:0] decode(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'b1000000: r = {2'b00, 4'h0};
         7'b1111001: r = {2'b00, 4'h1};
         7'b0100100: r = {2'b00, 4'h2};
         7'b0110000: r = {2'b00, 4'h3};
         7'b0011001: r = {2'b00, 4'h4};
         7'b0010010: r = {2'b00, 4'h5};
         7'b0000010: r = {2'b00, 4'h6};
         7'b1111000: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0010000: r = {2'b00, 4'h9};
         7'b1111111: r = {2'b01, 4'h0};
`ifdef SEG_CAPTURE_HEX_EN
         7'b0001000: r = {2'b00, 4'hA};
         7'b0000011: r = {2'b00, 4'hB};
         7'b1000110: r = {2'b00, 4'hC};
         7'b0100001: r = {2'b00, 4'hD};
         7'b0000110: r = {2'b00, 4'hE};
         7'b0001110: r = {2'b00, 4'hF};
`endif
         default:    r = {2'b10, 4'hF};
      endcase
      return r;
   endfunction

   assign samp_now = {an_n, segs_n};
   assign sel      = ~an_n;
   assign sel_any  = |sel;
   assign sel_one  = sel_any && ((sel & (sel - NDIG'(1))) == '0);
   assign multi    = sel_any && !sel_one;
   assign dec      = decode(segs_n);

   // A multi-select cycle always restarts the run, even if it repeats the last sample.
   assign new_run = (samp_now != samp_q) || multi;
   assign run_d   = new_run            ? 8'd1  :
                    (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
   // First arrival at RUN_MAX only; the new_run term covers STABLE_CYCLES == 1.
   assign capture = (state_q == COLLECT) && sel_one && (run_d == RUN_MAX) &&
                    (new_run || (run_q != RUN_MAX));

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      slot_d   = slot_q;
      sblank_d = sblank_q;
      serr_d   = serr_q;
      fdig_d   = fdig_q;
      fblank_d = fblank_q;
      ferr_d   = ferr_q;
      case (state_q)
         COLLECT: begin
            if (capture) begin
               for (int unsigned i = 0; i < NDIG; i++) begin
                  if (sel[i]) begin
                     slot_d[4*i +: 4] = dec[3:0];
                     sblank_d[i]      = dec[4];
                     serr_d[i]        = dec[5];
                     mask_d[i]        = 1'b1;
                  end
               end
            end
            if (mask_q == '1) begin
               fdig_d   = slot_q;
               fblank_d = sblank_q;
               ferr_d   = serr_q;
               state_d  = PRESENT;
            end
         end
         PRESENT: begin
            if (frame_ready) begin
               mask_d  = '0;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         samp_q   <= '0;
         run_q    <= '0;
         mask_q   <= '0;
         slot_q   <= '0;
         sblank_q <= '0;
         serr_q   <= '0;
         fdig_q   <= '0;
         fblank_q <= '0;
         ferr_q   <= '0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         samp_q   <= samp_now;
         run_q    <= run_d;
         mask_q   <= mask_d;
         slot_q   <= slot_d;
         sblank_q <= sblank_d;
         serr_q   <= serr_d;
         fdig_q   <= fdig_d;
         fblank_q <= fblank_d;
         ferr_q   <= ferr_d;
         glitch_q <= multi;
      end
   end

   assign frame_valid  = (state_q == PRESENT);
   assign frame_digits = fdig_q;
   assign frame_blank  = fblank_q;
   assign frame_err    = ferr_q;
   assign glitch       = glitch_q;

endmodule

// File: doc/seg_capture_n.md
Name: seg_capture_n

Overview:
- Receive-side counterpart of the team's active-low seven-segment decoder.
- Monitors a multiplexed active-low display bus: segment lines plus active-low digit enables.
- Qualifies each digit's pattern for stability, decodes it back to a 4-bit value, and assembles one value per digit position into a frame.
- The frame is handed out over a valid/ready handshake. Used as an in-system display monitor and as a self-checking scoreboard front end.

Parameters:
- NDIG, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is captured (1..255).

Ports:
- clk  input  1  system clock; all inputs are synchronous to clk.
- rst_n  input  1  synchronous active-low reset.
- segs_n  input  7  active-low segments; bit 6 = g, bit 0 = a.
- an_n  input  NDIG  active-low digit enables; bit i low selects digit i.
- frame_ready  input  1  consumer accepts the frame.
- frame_valid  output  1  frame_digits/frame_blank/frame_err hold a complete frame.
- frame_digits  output  4*NDIG  decoded values; digit i in bits [4i+3:4i].
- frame_blank  output  NDIG  digit i captured as all segments off.
- frame_err  output  NDIG  digit i captured as an undecodable pattern.
- glitch  output  1  one-cycle pulse when more than one an_n bit is low.

Behaviour:
- Clock and reset: single clock domain, rising edge. Reset is synchronous, active-low. Reset values:
  - frame_valid=0, frame_digits=0, frame_blank=0, frame_err=0, glitch=0.
  - Capture mask, stability counter and previous-sample registers cleared.
  - FSM enters COLLECT.
- Sample: {an_n, segs_n} is registered every cycle.
  - Run length L counts consecutive edges on which the sample equals the previous one. L restarts at 1 when it differs, and saturates at STABLE_CYCLES.
- Select validity:
  - Exactly one an_n bit low: valid selection.
  - All an_n high: idle; no capture, no glitch.
  - Two or more low: glitch=1 for each such cycle, no capture, L restarts.
- Capture (COLLECT only): on the edge where L first reaches STABLE_CYCLES with a valid selection of digit i:
  - Decode segs_n into working slot i and set mask bit i.
  - Exactly one capture per run. A later run on the same digit overwrites slot i.
- Decode table (segs_n, gfedcba):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111: value 0, blank=1.
  - Any other pattern: value 0xF, err=1.
- FSM:
  - COLLECT: when the mask becomes all ones, copy the working slots to the frame outputs. frame_valid=1 on the next cycle; go to PRESENT.
  - PRESENT: frame outputs held stable. Captures suspended; glitch still reported. On frame_valid&&frame_ready: frame_valid=0, mask cleared, back to COLLECT.
  - Capture resumes the cycle after the handshake. The run length is not reset by the handshake.
- Latency: the frame is valid 1 cycle after the edge capturing the last missing digit.
- Boundaries:
  - frame_ready held high: frames stream back to back, at most one per full scan.
  - Reset mid-frame or mid-handshake: everything discarded, frame_valid=0 next cycle.
  - STABLE_CYCLES=1: capture on the first sample of each new run.
  - Digits may arrive in any order.

Optional Feature:
- Macro: SEG_CAPTURE_HEX_EN.
- Defined: the decode additionally accepts hex patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. These give values 0xA-0xF with err=0.
- Undefined: those patterns decode as err=1, value 0xF, as above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs → all outputs 0, no frame_valid after release until a full scan completes.
- NDIG=4, STABLE_CYCLES=4, frame_ready=1. Scan digits 0..3 showing 1,2,3,4 for 6 cycles each → one frame_valid pulse, frame_digits=16'h4321, blank=0, err=0, asserted 1 cycle after digit 3's 4th sample.
- Digit 2 held only 3 cycles per scan → no capture for digit 2, frame_valid never asserts. Hold it 4 cycles → frame completes.
- Segments 1111111 on digit 1, 0101010 on digit 3 → frame_blank=4'b0010, frame_err=4'b1000, digit 3 value 0xF. With SEG_CAPTURE_HEX_EN, pattern 0001000 yields 0xA, err=0.
- Backpressure: frame_ready=0 for 20 cycles while the display changes → frame outputs constant, frame_valid=1. Assert frame_ready for 1 cycle → handshake, next frame reflects post-handshake captures only.
- an_n=4'b1001 for 2 cycles → glitch high exactly 2 cycles, no capture. rst_n low during PRESENT → frame_valid=0 the following cycle.
